rv_uart_dbus: RTL

- Memory-mapped 8N1 UART peripheral on the rv32_core data bus (adr/we/re/dw/dr). Sits downstream of the core, decoded by base address.
- Provides the TXD/RXD serial pair to the debug terminal.
- TX and RX FIFOs let firmware console output and input run without stalling the core.
- Drives a level interrupt into the core's eirq input.

---
 rtl/rv_types.sv | 26 ++
 rtl/rv_sync_fifo.sv | 51 +++++
 rtl/rv_uart_dbus.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv_types.sv
// Shared rv32 types plus the UART register offsets and STAT bit positions.
// Latency: none, declarations only.
// Backpressure: not applicable.
package rv_types;

  typedef logic [31:0] u32_t;
  typedef logic [7:0]  u8_t;
  typedef logic [3:0]  u4_t;

  // Register offsets, as seen on adr[3:2]
  localparam logic [1:0] UART_DATA = 2'd0;
  localparam logic [1:0] UART_STAT = 2'd1;
  localparam logic [1:0] UART_BAUD = 2'd2;
  localparam logic [1:0] UART_CTRL = 2'd3;

  // STAT bit positions
  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_RX_VALID = 2;
  localparam int STAT_RX_OVR   = 3;
  localparam int STAT_TX_BUSY  = 4;

  // Shared by the TX and RX serial state machines
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_t;

endpackage

// File: rtl/rv_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and occupancy count.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module rv_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  cclk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_dat,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_dat,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  // Extra pointer bit keeps full and empty distinct; count can never exceed DEPTH
  assign count    = wr_ptr - rd_ptr;
  assign full     = count[DEPTH_LOG2];
  assign empty    = (wr_ptr == rd_ptr);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Pointer update
  always_ff @(posedge cclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage, no reset needed
  always_ff @(posedge cclk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_dat;
  end

endmodule

// File: rtl/rv_uart_dbus.sv
// Memory-mapped 8N1 UART on the rv32 data bus with TX/RX FIFOs and level irq.
// Latency: read data one cycle after re; writes act on the strobe edge.
// Backpressure: none on the bus; TX pushes to a full FIFO and RX bytes into a full FIFO are dropped.
module rv_uart_dbus
  import rv_types::*;
#(
  parameter logic [31:0] BASE       = 32'hFFFF_0000,
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        cclk,
  input  logic        reset,
  input  logic [31:0] adr,
  input  logic [3:0]  we,
  input  logic        re,
  input  logic [31:0] dw,
  output logic [31:0] dr,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);

  logic                sel, wr, rd;
  logic [1:0]          off;
  logic [15:0]         div;
  logic [1:0]          ctrl;
  logic                overrun;
  u32_t                stat, rd_mux;

  logic                tx_push, tx_pop, tx_full, tx_empty;
  u8_t                 tx_head;
  logic [DEPTH_LOG2:0] tx_count;
  uart_st_t            tx_st;
  logic [15:0]         tx_cnt;
  u8_t                 tx_sh;
  logic [2:0]          tx_bit;

  logic                rx_push, rx_pop, rx_full, rx_empty, rx_stop_ok, rx_drop;
  u8_t                 rx_head;
  logic [DEPTH_LOG2:0] rx_count;
  uart_st_t            rx_st;
  logic [15:0]         rx_cnt, rx_half_ld;
  logic [16:0]         div_p1;
  u8_t                 rx_sh;
  logic [2:0]          rx_bit;
  logic                rx_s1, rx_s2, rx_prev;

  logic                unused_bits;

  assign sel = (adr[31:4] == BASE[31:4]);
  assign off = adr[3:2];
  assign wr  = sel & (|we);
  assign rd  = sel & re;

  assign tx_push = wr & we[0] & (off == UART_DATA);
  assign rx_pop  = rd & (off == UART_DATA) & ~rx_empty;

  // Mid-bit point of the start bit; one cycle is already spent detecting the edge
  assign div_p1     = {1'b0, div} + 17'd1;
  assign rx_half_ld = (div_p1[16:1] == 16'd0) ? 16'd0 : div_p1[16:1] - 16'd1;

  assign rx_stop_ok = (rx_st == S_STOP) & (rx_cnt == 16'd0) & rx_s2;
  assign rx_push    = rx_stop_ok & (~rx_full | rx_pop);
  assign rx_drop    = rx_stop_ok & rx_full & ~rx_pop;

  assign unused_bits = &{1'b0, adr[1:0], dw[31:16], tx_count};

  rv_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .cclk(cclk), .reset(reset), .push(tx_push), .push_dat(dw[7:0]), .pop(tx_pop),
    .head_dat(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  rv_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .cclk(cclk), .reset(reset), .push(rx_push), .push_dat(rx_sh), .pop(rx_pop),
    .head_dat(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // TX FSM pops from IDLE, or from the end of STOP for gapless back-to-back frames
  always_comb begin
    tx_pop = ~tx_empty & ((tx_st == S_IDLE) | ((tx_st == S_STOP) & (tx_cnt == 16'd0)));
  end

  // Status word and read-data mux
  always_comb begin
    stat                = '0;
    stat[STAT_TX_FULL]  = tx_full;
    stat[STAT_TX_EMPTY] = tx_empty;
    stat[STAT_RX_VALID] = ~rx_empty;
    stat[STAT_RX_OVR]   = overrun;
    stat[STAT_TX_BUSY]  = (tx_st != S_IDLE) | ~tx_empty;
    stat[15:8]          = 8'(rx_count);
    rd_mux              = '0;
    case (off)
      UART_DATA: rd_mux = rx_empty ? 32'd0 : {24'd0, rx_head};
      UART_STAT: rd_mux = stat;
      UART_BAUD: rd_mux = {16'd0, div};
      UART_CTRL: rd_mux = {30'd0, ctrl};
      default:   rd_mux = '0;
    endcase
  end

  // Register writes, registered read data and interrupt
  always_ff @(posedge cclk) begin
    if (reset) begin
      div     <= DIV_RESET;
      ctrl    <= '0;
      overrun <= 1'b0;
      dr      <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr && off == UART_BAUD) begin
        if (we[0]) div[7:0]  <= dw[7:0];
        if (we[1]) div[15:8] <= dw[15:8];
      end
      if (wr && off == UART_CTRL) ctrl <= dw[1:0];
      if (rx_drop) overrun <= 1'b1;
      else if (wr && off == UART_STAT && dw[STAT_RX_OVR]) overrun <= 1'b0;
      dr  <= rd ? rd_mux : 32'd0;
      irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty & (tx_st == S_IDLE));
    end
  end

  // TX serialiser: each state holds for div+1 cycles, data LSB first
  always_ff @(posedge cclk) begin
    if (reset) begin
      tx_st  <= S_IDLE;
      tx_cnt <= '0;
      tx_sh  <= '0;
      tx_bit <= '0;
      txd    <= 1'b1;
    end else begin
      case (tx_st)
        S_IDLE: begin
          txd <= 1'b1;
          if (tx_pop) begin
            tx_st  <= S_START;
            tx_cnt <= div;
            tx_sh  <= tx_head;
            txd    <= 1'b0;
          end
        end
        S_START: begin
          if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
          else begin
            tx_st  <= S_DATA;
            tx_cnt <= div;
            tx_bit <= 3'd0;
            txd    <= tx_sh[0];
          end
        end
        S_DATA: begin
          if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
          else begin
            tx_cnt <= div;
            if (tx_bit == 3'd7) begin
              tx_st <= S_STOP;
              txd   <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              tx_sh  <= {1'b0, tx_sh[7:1]};
              txd    <= tx_sh[1];
            end
          end
        end
        S_STOP: begin
          if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
          else if (tx_pop) begin
            tx_st  <= S_START;
            tx_cnt <= div;
            tx_sh  <= tx_head;
            txd    <= 1'b0;
          end else begin
            tx_st <= S_IDLE;
            txd   <= 1'b1;
          end
        end
        default: tx_st <= S_IDLE;
      endcase
    end
  end

  // RX synchroniser and deserialiser sampling at mid-bit
  always_ff @(posedge cclk) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= S_IDLE;
      rx_cnt  <= '0;
      rx_sh   <= '0;
      rx_bit  <= '0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_st)
        S_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_st  <= S_START;
            rx_cnt <= rx_half_ld;
          end
        end
        S_START: begin
          if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
          else if (rx_s2) rx_st <= S_IDLE;
          else begin
            rx_st  <= S_DATA;
            rx_cnt <= div;
            rx_bit <= 3'd0;
          end
        end
        S_DATA: begin
          if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
          else begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= div;
            if (rx_bit == 3'd7) rx_st <= S_STOP;
            else rx_bit <= rx_bit + 3'd1;
          end
        end
        S_STOP: begin
          // Push or framing discard is decoded combinationally from this state
          if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
          else rx_st <= S_IDLE;
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

endmodule
